// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back stage and integer register file. This block takes the
//            MEM/WB pipeline register outputs, selects the write-back value
//            and commits it to the register file. It also provides two
//            combinational decode read ports, which bypass a write in the
//            same cycle, plus a registered debug read port and a counter of
//            retired writes.
// Ports    : clk, rst                 clock and synchronous active-high reset
//            alu_result_wb            ALU result from MEM/WB
//            mem_data_mem_wb          load data from MEM/WB
//            memtoreg_mem_wb          1 selects load data, 0 selects ALU result
//            rd_wb_out, regwrite_wb_out  destination register and write enable
//            rs1_addr/rs1_data        read port 1 (combinational)
//            rs2_addr/rs2_data        read port 2 (combinational)
//            wb_data                  selected write-back value (combinational)
//            dbg_addr/dbg_data        debug read port (1-cycle latency)
//            wb_count                 committed writes since reset (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  alu_result_wb,
  input  logic [AW-1:0]    rd_wb_out,
  input  logic             regwrite_wb_out,
  input  logic [XLEN-1:0]  mem_data_mem_wb,
  input  logic             memtoreg_mem_wb,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic [AW-1:0]    dbg_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  dbg_data,
  output logic [CNT_W-1:0] wb_count
);

  // Entry 0 exists only so that the array can be indexed directly. It is
  // never written after reset and never read, because every read of
  // address 0 is forced to zero.
  logic [XLEN-1:0] regs [NREGS];
  logic            we;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            dbg_hit;

  assign wb_data = memtoreg_mem_wb ? mem_data_mem_wb : alu_result_wb;

  // A write to x0 is not a commit. Reset suppresses the write, so a write
  // presented in the reset cycle is dropped.
  assign we = regwrite_wb_out && (rd_wb_out != '0) && !rst;

  assign rs1_hit = we && (rs1_addr == rd_wb_out);
  assign rs2_hit = we && (rs2_addr == rd_wb_out);
  assign dbg_hit = we && (dbg_addr == rd_wb_out);

  // Write-before-read: when a read port and the commit target the same
  // register in one cycle, the read returns the value being written. While
  // reset is asserted, both read ports return zero, whatever the array holds.
  assign rs1_data = (rst || rs1_addr == '0) ? '0
                  : rs1_hit                 ? wb_data
                  :                           regs[rs1_addr];

  assign rs2_data = (rst || rs2_addr == '0) ? '0
                  : rs2_hit                 ? wb_data
                  :                           regs[rs2_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[rd_wb_out] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data <= '0;
    end else if (dbg_addr == '0) begin
      dbg_data <= '0;
    end else if (dbg_hit) begin
      dbg_data <= wb_data;
    end else begin
      dbg_data <= regs[dbg_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count <= '0;
    end else if (we) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. It uses a directed vector
//            table with hand-computed expectations, followed by randomized
//            cycles checked against an array-based reference model. A second
//            instance with a 4-bit counter checks counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  typedef struct {
    logic        rst;
    logic        regwrite;
    logic [4:0]  rd;
    logic        memtoreg;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  dbga;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_wb;
    logic [31:0] exp_dbg;   // expected dbg_data after the clock edge
    logic [31:0] exp_cnt;   // expected wb_count after the clock edge
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_wb;
  logic [4:0]  rd_wb_out;
  logic        regwrite_wb_out;
  logic [31:0] mem_data_mem_wb;
  logic        memtoreg_mem_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [31:0] dbg_data;
  logic [31:0] wb_count;
  logic [31:0] rs1_data4;
  logic [31:0] rs2_data4;
  logic [31:0] wb_data4;
  logic [31:0] dbg_data4;
  logic [3:0]  wb_count4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the architectural register contents and a plain
  // integer count of commits since reset.
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .alu_result_wb(alu_result_wb), .rd_wb_out(rd_wb_out),
    .regwrite_wb_out(regwrite_wb_out), .mem_data_mem_wb(mem_data_mem_wb),
    .memtoreg_mem_wb(memtoreg_mem_wb), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .dbg_addr(dbg_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data(wb_data), .dbg_data(dbg_data),
    .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .alu_result_wb(alu_result_wb), .rd_wb_out(rd_wb_out),
    .regwrite_wb_out(regwrite_wb_out), .mem_data_mem_wb(mem_data_mem_wb),
    .memtoreg_mem_wb(memtoreg_mem_wb), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .dbg_addr(dbg_addr), .rs1_data(rs1_data4),
    .rs2_data(rs2_data4), .wb_data(wb_data4), .dbg_data(dbg_data4),
    .wb_count(wb_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus. The combinational outputs are checked
  // before the edge, and the registered outputs just after it. The model
  // is then advanced by the architectural rules.
  task automatic step(input vec_t v);
    logic        commit;
    logic [31:0] wbv;
    rst             = v.rst;
    regwrite_wb_out = v.regwrite;
    rd_wb_out       = v.rd;
    memtoreg_mem_wb = v.memtoreg;
    alu_result_wb   = v.alu;
    mem_data_mem_wb = v.mem;
    rs1_addr        = v.rs1a;
    rs2_addr        = v.rs2a;
    dbg_addr        = v.dbga;
    #2;
    chk("rs1_data", rs1_data, v.exp_rs1);
    chk("rs2_data", rs2_data, v.exp_rs2);
    chk("wb_data",  wb_data,  v.exp_wb);
    @(posedge clk);
    #1;
    chk("dbg_data", dbg_data, v.exp_dbg);
    chk("wb_count", wb_count, v.exp_cnt);
    chk("wb_count4", {28'd0, wb_count4}, {28'd0, v.exp_cnt[3:0]});
    wbv    = v.memtoreg ? v.mem : v.alu;
    commit = v.regwrite && (v.rd != 5'd0) && !v.rst;
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
      mdl_cnt = 32'd0;
    end else if (commit) begin
      mdl_regs[v.rd] = wbv;
      mdl_cnt        = mdl_cnt + 32'd1;
    end
  endtask

  function automatic logic [31:0] mdl_read(input vec_t v, input logic [4:0] a);
    logic [31:0] wbv;
    wbv = v.memtoreg ? v.mem : v.alu;
    if (v.rst || a == 5'd0)                             return 32'd0;
    if (v.regwrite && v.rd != 5'd0 && a == v.rd)        return wbv;
    return mdl_regs[a];
  endfunction

  // Fill in the expected outputs of a vector from the model's current state.
  function automatic vec_t model_expect(input vec_t v);
    vec_t r;
    r         = v;
    r.exp_rs1 = mdl_read(v, v.rs1a);
    r.exp_rs2 = mdl_read(v, v.rs2a);
    r.exp_wb  = v.memtoreg ? v.mem : v.alu;
    r.exp_dbg = mdl_read(v, v.dbga);
    if (v.rst)                                r.exp_cnt = 32'd0;
    else if (v.regwrite && v.rd != 5'd0)      r.exp_cnt = mdl_cnt + 32'd1;
    else                                      r.exp_cnt = mdl_cnt;
    return r;
  endfunction

  vec_t tbl [10];

  initial begin
    vec_t v;
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_cnt = 32'd0;

    //           rst we rd  m2r alu           mem           rs1 rs2 dbg  exp_rs1       exp_rs2       exp_wb        exp_dbg       cnt
    tbl[0] = '{1'b0,1'b1,5'd5,1'b0,32'hDEADBEEF,32'h00000000,5'd5,5'd0,5'd5, 32'hDEADBEEF,32'h0,        32'hDEADBEEF,32'hDEADBEEF,32'd1};
    tbl[1] = '{1'b0,1'b0,5'd5,1'b0,32'h00000000,32'h00000000,5'd0,5'd5,5'd0, 32'h0,       32'hDEADBEEF,32'h0,        32'h0,        32'd1};
    tbl[2] = '{1'b0,1'b1,5'd7,1'b1,32'hFFFFFFFF,32'h12345678,5'd7,5'd5,5'd7, 32'h12345678,32'hDEADBEEF,32'h12345678,32'h12345678,32'd2};
    tbl[3] = '{1'b0,1'b1,5'd0,1'b0,32'hFFFFFFFF,32'h00000000,5'd0,5'd7,5'd0, 32'h0,       32'h12345678,32'hFFFFFFFF,32'h0,        32'd2};
    tbl[4] = '{1'b0,1'b0,5'd0,1'b0,32'h00000000,32'h00000000,5'd0,5'd0,5'd0, 32'h0,       32'h0,        32'h0,        32'h0,        32'd2};
    tbl[5] = '{1'b0,1'b1,5'd3,1'b0,32'h00000011,32'h00000000,5'd3,5'd3,5'd3, 32'h11,      32'h11,       32'h11,       32'h11,       32'd3};
    tbl[6] = '{1'b0,1'b1,5'd3,1'b0,32'h00000022,32'h00000000,5'd3,5'd3,5'd3, 32'h22,      32'h22,       32'h22,       32'h22,       32'd4};
    tbl[7] = '{1'b0,1'b1,5'd9,1'b0,32'h000000A5,32'h00000000,5'd9,5'd3,5'd9, 32'hA5,      32'h22,       32'hA5,       32'hA5,       32'd5};
    tbl[8] = '{1'b1,1'b1,5'd9,1'b0,32'h0000005A,32'h00000000,5'd9,5'd3,5'd9, 32'h0,       32'h0,        32'h5A,       32'h0,        32'd0};
    tbl[9] = '{1'b0,1'b0,5'd9,1'b0,32'h00000000,32'h00000000,5'd9,5'd3,5'd9, 32'h0,       32'h0,        32'h0,        32'h0,        32'd0};

    // Reset for two cycles, then read every address with writes disabled.
    v = '{1'b1,1'b0,5'd0,1'b0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,32'd0};
    step(v);
    step(v);
    for (int a = 0; a < 32; a++) begin
      v = '{1'b0,1'b0,5'd0,1'b0,32'h0,32'h0,5'(a),5'(31 - a),5'(a),32'h0,32'h0,32'h0,32'h0,32'd0};
      step(v);
    end

    // Directed table: ALU write, load write, x0 guard, same-cycle
    // read/write, reset colliding with a write.
    for (int i = 0; i < 10; i++) step(tbl[i]);

    // Randomized cycles checked against the model. The read addresses are
    // often steered onto rd so that the bypass path is exercised.
    for (int n = 0; n < 300; n++) begin
      v.rst      = ($urandom_range(0, 39) == 0);
      v.regwrite = ($urandom_range(0, 9) < 7);
      v.rd       = 5'($urandom_range(0, 31));
      v.memtoreg = 1'($urandom);
      v.alu      = $urandom;
      v.mem      = $urandom;
      v.rs1a     = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
      v.rs2a     = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
      v.dbga     = ($urandom_range(0, 3) == 0) ? v.rd : 5'($urandom_range(0, 31));
      step(model_expect(v));
    end

    // Counter wrap: after reset, 16 commits bring the 4-bit counter back to 0.
    v = '{1'b1,1'b0,5'd0,1'b0,32'h0,32'h0,5'd0,5'd0,5'd0,32'h0,32'h0,32'h0,32'h0,32'd0};
    step(model_expect(v));
    for (int n = 0; n < 16; n++) begin
      v = '{1'b0,1'b1,5'($urandom_range(1, 31)),1'b0,$urandom,32'h0,
            5'($urandom_range(0, 31)),5'($urandom_range(0, 31)),5'($urandom_range(0, 31)),
            32'h0,32'h0,32'h0,32'h0,32'd0};
      step(model_expect(v));
    end
    chk("wrap_count4", {28'd0, wb_count4}, 32'd0);
    chk("wrap_count32", wb_count, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
